// File: rtl/ex_div_ctrl.sv
// Iterative restoring divider sequencer for the EX stage (MIPS DIV/DIVU).
// Latches operands on an accepted start, runs one quotient bit per cycle,
// applies the signed fix-up and holds {remainder, quotient} for HI/LO
// while the pipeline keeps start_i high.
module ex_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_i,
  input  logic               start_i,
  input  logic               cancel_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_FREE,
    S_DIVZERO,
    S_ON,
    S_END
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   dvsr;
  logic               neg_quot;
  logic               neg_rem;
  logic [2*WIDTH-1:0] result;

  logic               accept;
  logic               done;
  logic [WIDTH-1:0]   dividend_abs;
  logic [WIDTH-1:0]   divisor_abs;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // A flush on the same cycle as a request wins: nothing is latched.
  assign accept = (state == S_FREE) && start_i && !cancel_i;
  assign done   = (cnt == CW'(WIDTH));

  // Magnitudes for DIV; DIVU passes operands through untouched.
  assign dividend_abs = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign divisor_abs  = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

  // Restoring step: bring the next dividend bit into the partial remainder
  // and try to subtract; the top bit of the difference is the borrow.
  assign trial = {rem, quot[WIDTH-1]} - {1'b0, dvsr};

  // Quotient truncates toward zero, remainder follows the dividend's sign.
  // The most-negative / -1 case falls out naturally as 0x80..0 / 0.
  assign quot_fix = neg_quot ? -quot : quot;
  assign rem_fix  = neg_rem  ? -rem  : rem;

  // State register.
  // NOTE: every clocked register uses non-blocking (<=) so all flops update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FREE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a flush overrides every transition.
  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_FREE: begin
        if (accept) begin
          state_nx = (divisor_i == '0) ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: state_nx = S_END;
      S_ON: begin
        if (done) begin
          state_nx = S_END;
        end
      end
      S_END: begin
        if (!start_i) begin
          state_nx = S_FREE;
        end
      end
      default: state_nx = S_FREE;
    endcase
    if (cancel_i) begin
      state_nx = S_FREE;
    end
  end

  // Datapath: operand capture, iteration, and result load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      rem      <= '0;
      quot     <= '0;
      dvsr     <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        S_FREE: begin
          if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            quot     <= dividend_abs;
            dvsr     <= divisor_abs;
            neg_quot <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            neg_rem  <= signed_i & dividend_i[WIDTH-1];
          end
        end
        S_DIVZERO: begin
          result <= '0;
        end
        S_ON: begin
          if (!done) begin
            cnt <= cnt + CW'(1);
            if (!trial[WIDTH]) begin
              rem  <= trial[WIDTH-1:0];
              quot <= {quot[WIDTH-2:0], 1'b1};
            end else begin
              rem  <= {rem[WIDTH-2:0], quot[WIDTH-1]};
              quot <= {quot[WIDTH-2:0], 1'b0};
            end
          end else begin
            result <= {rem_fix, quot_fix};
          end
        end
        default: ;
      endcase
    end
  end

  // Result is only visible in END, so a discarded run never leaks out.
  assign ready_o  = (state == S_END);
  assign result_o = ready_o ? result : '0;

  // Freeze the front of the pipe while a division is requested or running;
  // a flush releases it in the same cycle.
  assign stallreq_o = !cancel_i &&
                      ((state == S_ON) || (state == S_DIVZERO) ||
                       ((state == S_FREE) && start_i));

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Bench for ex_div_ctrl: directed corner cases plus randomized divisions.
// Expected results are queued at issue time and consumed by a monitor
// on each rising edge of ready_o; control timing is checked per cycle.
module tb_ex_div_ctrl;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           signed_i = 1'b0;
  logic           start_i = 1'b0;
  logic           cancel_i = 1'b0;
  logic [W-1:0]   dividend_i = '0;
  logic [W-1:0]   divisor_i = '0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stallreq_o;

  int             n_vec = 0;
  int             n_err = 0;
  logic [2*W-1:0] sb_q[$];
  logic           ready_q = 1'b0;

  ex_div_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .signed_i   (signed_i),
    .start_i    (start_i),
    .cancel_i   (cancel_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: language-level division; DIV truncates toward zero and the
  // remainder takes the dividend's sign, which is what SV / and % give.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic [W-1:0]        q;
    logic [W-1:0]        r;
    sa = a;
    sb = b;
    if (b == '0) return '0;
    if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) begin
      q = a;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  // Monitor: pop one expectation per ready_o rising edge.
  always @(negedge clk) begin
    if (rst) begin
      if (ready_o && !ready_q) begin
        if (sb_q.size() == 0) check("unexpected_ready", ready_o, 0);
        else check("result", result_o, sb_q.pop_front());
      end
      if (!ready_o) check("result_idle_zero", result_o, 0);
    end
    ready_q <= ready_o;
  end

  // One division from the EX stage's point of view. Called #1 after a
  // posedge; returns #1 after a posedge with the DUT back in FREE.
  // cancel_at < 0 means run to completion and hold start for 'hold' extra cycles.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int cancel_at, input int hold);
    int exp_lat;
    exp_lat    = (b == '0) ? 2 : W + 2;
    start_i    = 1'b1;
    cancel_i   = (cancel_at == 0);
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    if (cancel_at < 0) sb_q.push_back(model(a, b, s));
    for (int c = 0; c <= W + 4; c++) begin
      if (c > 0) begin
        dividend_i = $urandom;
        divisor_i  = $urandom;
        signed_i   = 1'($urandom_range(0, 1));
        cancel_i   = (c == cancel_at);
      end
      @(negedge clk);
      if (cancel_at >= 0) begin
        check("stall_cancel", stallreq_o, c < cancel_at);
        check("ready_cancel", ready_o, 0);
        if (c == cancel_at) break;
      end else begin
        check("stall", stallreq_o, c < exp_lat);
        check("ready", ready_o, c == exp_lat);
        if (c == exp_lat) break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (cancel_at >= 0) begin
      cancel_i = 1'b0;
      start_i  = 1'b0;
      @(negedge clk);
      check("post_cancel_stall", stallreq_o, 0);
      check("post_cancel_ready", ready_o, 0);
      @(posedge clk); #1;
    end else begin
      repeat (hold) begin
        @(negedge clk);
        check("hold_ready", ready_o, 1);
        check("hold_stall", stallreq_o, 0);
        @(posedge clk); #1;
      end
      start_i = 1'b0;
      @(negedge clk);
      check("release_ready", ready_o, 1);
      check("release_stall", stallreq_o, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", ready_o, 0);
    check("reset_result", result_o, 0);
    check("reset_stall", stallreq_o, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_div(32'd100, 32'd7, 1'b0, -1, 0);
    do_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, -1, 1);
    do_div(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, -1, 2);
    do_div(32'h0000_1234, 32'h0, 1'b0, -1, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, 0);

    // Flush mid-run, then a fresh start two cycles later.
    do_div(32'hDEAD_BEEF, 32'h0000_0013, 1'b0, 10, 0);
    do_div(32'hDEAD_BEEF, 32'h0000_0013, 1'b0, -1, 0);
    // Flush in DIVZERO, and flush coinciding with the request.
    do_div(32'h0000_0055, 32'h0, 1'b1, 1, 0);
    do_div(32'h0000_0055, 32'h0000_0003, 1'b1, 0, 0);
    do_div(32'hFFFF_FF00, 32'h0000_0010, 1'b1, -1, 0);

    // Asynchronous reset in the middle of a run.
    start_i    = 1'b1;
    dividend_i = 32'h0001_0000;
    divisor_i  = 32'h0000_0009;
    signed_i   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("pre_reset_stall", stallreq_o, 1);
      @(posedge clk); #1;
    end
    #2;
    rst     = 1'b0;
    start_i = 1'b0;
    #1;
    check("async_reset_ready", ready_o, 0);
    check("async_reset_result", result_o, 0);
    check("async_reset_stall", stallreq_o, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("after_reset_ready", ready_o, 0);
      check("after_reset_stall", stallreq_o, 0);
    end
    @(posedge clk); #1;

    // Randomized back-to-back divisions.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = -W'($urandom_range(1, 15));
        3:       b = {W{1'b1}};
        default: b = $urandom;
      endcase
      do_div(a, b, 1'($urandom_range(0, 1)), -1, $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_div_ctrl.md
Name: ex_div_ctrl

Overview:
- Multi-cycle iterative divider sequencer for the EX stage; serves MIPS DIV/DIVU.
- Latches operands on a start request and runs one restoring-division step per cycle.
- Holds the pipeline through stallreq_o while busy, and presents {remainder, quotient} for the HI/LO write.
- Accepts an annul request from the exception/flush logic.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- signed_i  input  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
- start_i  input  1  division request; held high by EX until ready_o is seen.
- cancel_i  input  1  annul the current or pending division (flush/exception).
- dividend_i  input  WIDTH  dividend; sampled only on accepted start.
- divisor_i  input  WIDTH  divisor; sampled only on accepted start.
- result_o  output  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO.
- ready_o  output  1  result valid.
- stallreq_o  output  1  request to freeze IF/ID/EX.

Behaviour:
- Reset (rst=0, async): state FREE, counter 0, internal registers 0, result_o 0, ready_o 0, stallreq_o 0.
- States: FREE, DIVZERO, ON, END. State, counter, partial remainder, quotient and result are registered.
- Accept condition: state FREE, start_i=1, cancel_i=0.
- FREE, on accept with divisor_i=0: go to DIVZERO.
- FREE, on accept with divisor_i≠0: go to ON.
  - Latch |dividend| and |divisor| when signed_i=1; raw values otherwise.
  - Latch the sign flags; clear the counter and partial remainder.
- DIVZERO: next cycle go to END with the result forced to 0.
- ON, counter<WIDTH: one restoring step, counter+1.
  - Step: shift {rem,quot} left 1; trial = rem - divisor.
  - If no borrow: rem = trial, quot LSB = 1; else quot LSB = 0.
- ON, counter==WIDTH: apply sign fix-up, load result, go to END.
- Sign fix-up (signed_i=1 only):
  - Quotient is negated if the operand signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF returns quotient 0x80000000, remainder 0. No trap is raised.
- END:
  - ready_o=1; result_o holds the result.
  - Stays in END while start_i=1; goes to FREE the cycle after start_i=0.
- Outputs outside END: ready_o=0 and result_o=0.
- Latency: accept at cycle 0 → ON for cycles 1..WIDTH+1 → END at cycle WIDTH+2 (cycle 34 for WIDTH=32). Divide-by-zero: END at cycle 2.
- stallreq_o (combinational):
  - 1 in DIVZERO and ON.
  - 1 in FREE when start_i=1 and cancel_i=0.
  - 0 in END and otherwise.
- cancel_i has priority over every transition. In DIVZERO, ON or END the next state is FREE: no ready_o pulse, stallreq_o drops in the cancel cycle, and the result is discarded.
- cancel_i and start_i together in FREE: not accepted, stays FREE.
- Operand changes after accept are ignored.
- Reset asserted mid-operation: immediate return to FREE with all outputs 0. No partial result is ever visible.

Test Plan:
- Unsigned 100 / 7, start held to ready → ready_o rises exactly at cycle 34; result_o = {0x00000002, 0x0000000E}; stallreq_o=1 on cycles 0..33 and 0 at cycle 34.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero, 0x1234 / 0 → ready_o at cycle 2, result_o = 0, stallreq_o high on cycles 0..1 only.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Same operands unsigned → quotient 0, remainder 0x80000000.
- cancel_i pulsed at cycle 10 of a run → state FREE at cycle 11, stallreq_o 0 from cycle 10, ready_o never asserts. A fresh start at cycle 12 completes correctly at cycle 46.
- Async reset dropped at cycle 20 between clock edges → outputs 0 immediately, state FREE. After release with start_i low, nothing asserts. Back-to-back divisions: start_i drops for one cycle after ready, second division starts, and its ready lands 34 cycles after its accept.
